// File: rtl/dbg_mon_mem_pkg.sv
// Shared types and jdo field layout for the debug monitor memory engine.
package dbg_mon_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_REQ  = 2'd1,
      ST_RD_DATA = 2'd2,
      ST_WR_REQ  = 2'd3
   } state_t;

   localparam int unsigned JDO_CLRERR_BIT = 2;
   localparam int unsigned JDO_WDATA_LSB  = 3;
   localparam int unsigned JDO_ADDR_LSB   = 17;
   localparam int unsigned JDO_RDLOAD_BIT = 35;
   localparam int unsigned JDO_BE_LSB     = 36;

   localparam logic [31:0] TIMEOUT_VALUE = 32'hDEAD_BEEF;

   // Two-bit lane select from the JTAG payload; both 00 and 11 mean a full word.
   function automatic logic [3:0] decode_be(input logic [1:0] i_sel);
      case (i_sel)
         2'b01:   return 4'h3;
         2'b10:   return 4'h1;
         default: return 4'hF;
      endcase
   endfunction

endpackage

// File: rtl/dbg_mon_mem_timeout.sv
// Stall counter for the monitor memory engine; pulses o_expire after TIMEOUT_CYC busy cycles in one state.
module dbg_mon_mem_timeout #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic i_run,
   input  logic i_clear,
   output logic o_expire
);

   logic [7:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_run) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // r_cnt counts completed stall cycles, so the TIMEOUT_CYC-th cycle sees TIMEOUT_CYC-1.
   assign o_expire = i_run && (r_cnt == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dbg_mon_mem_engine.sv
// Debug monitor memory engine: turns sysclk debug strobes into single-word Avalon-MM reads/writes.
// Optional stall abort is built when DBG_MEM_TIMEOUT_EN is defined.
module dbg_mon_mem_engine
   import dbg_mon_mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   output logic [3:0]        avm_byteenable,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_readdatavalid,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata, r_mon;
   logic [3:0]        r_be;
   logic              r_ready, r_error, r_overrun, r_got_data;

   logic w_idle, w_take_a, w_take_b, w_take_n, w_lost, w_busy_hit;
   logic w_done, w_expire, w_early_data, w_unused_ok;

   // Strobe arbitration: ocimem_b beats ocimem_a beats no_action; only honoured in IDLE.
   assign w_idle     = (r_state == ST_IDLE);
   assign w_take_b   = w_idle && take_action_ocimem_b;
   assign w_take_a   = w_idle && take_action_ocimem_a && !take_action_ocimem_b;
   assign w_take_n   = w_idle && take_no_action_ocimem_a && !take_action_ocimem_a && !take_action_ocimem_b;
   assign w_lost     = w_idle && ((take_action_ocimem_b && take_action_ocimem_a) ||
                                  (take_action_ocimem_b && take_no_action_ocimem_a) ||
                                  (take_action_ocimem_a && take_no_action_ocimem_a));
   assign w_busy_hit = !w_idle && (take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a);

   // Read data that arrives together with the accept is held until RD_DATA completes the op.
   assign w_early_data = (r_state == ST_RD_REQ) && !avm_waitrequest && avm_readdatavalid;

   // NOTE: the state register uses async reset so avm_read/avm_write, decoded from it, drop at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      avm_read    = 1'b0;
      avm_write   = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_take_b)                                    w_state_nxt = ST_WR_REQ;
            else if (w_take_a && jdo[JDO_RDLOAD_BIT])        w_state_nxt = ST_RD_REQ;
            else if (w_take_n)                               w_state_nxt = ST_RD_REQ;
         end
         ST_RD_REQ: begin
            avm_read = 1'b1;
            if (!avm_waitrequest) w_state_nxt = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            if (avm_readdatavalid || r_got_data) begin
               w_state_nxt = ST_IDLE;
               w_done      = 1'b1;
            end
         end
         ST_WR_REQ: begin
            avm_write = 1'b1;
            if (!avm_waitrequest) begin
               w_state_nxt = ST_IDLE;
               w_done      = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_expire) begin
         w_state_nxt = ST_IDLE;
         w_done      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr     <= '0;
         r_wdata    <= '0;
         r_be       <= 4'hF;
         r_mon      <= '0;
         r_ready    <= 1'b1;
         r_error    <= 1'b0;
         r_overrun  <= 1'b0;
         r_got_data <= 1'b0;
      end else begin
         if (w_take_a) begin
            r_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
            if (jdo[JDO_CLRERR_BIT]) begin
               r_error   <= 1'b0;
               r_overrun <= 1'b0;
            end
         end
         if (w_take_b) begin
            r_wdata <= jdo[JDO_WDATA_LSB +: 32];
            r_mon   <= jdo[JDO_WDATA_LSB +: 32];
            r_be    <= decode_be(jdo[JDO_BE_LSB +: 2]);
         end
         if (w_lost || w_busy_hit) r_overrun <= 1'b1;
         if (w_busy_hit)           r_error   <= 1'b1;

         if (w_early_data) begin
            r_mon      <= avm_readdata;
            r_got_data <= 1'b1;
         end
         if ((r_state == ST_RD_DATA) && avm_readdatavalid && !r_got_data) r_mon <= avm_readdata;
         if (w_done) begin
            r_addr     <= r_addr + ADDR_W'(1);
            r_got_data <= 1'b0;
         end
         if (w_expire) begin
            r_mon      <= TIMEOUT_VALUE;
            r_error    <= 1'b1;
            r_got_data <= 1'b0;
         end
         r_ready <= (w_state_nxt == ST_IDLE);
      end
   end

`ifdef DBG_MEM_TIMEOUT_EN
   dbg_mon_mem_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .i_run    (!w_idle),
      .i_clear  (w_state_nxt != r_state),
      .o_expire (w_expire)
   );
`else
   assign w_expire = 1'b0;
`endif

   // Overrun is kept as internal state only; jdo[1:0] carries nothing for this engine.
   assign w_unused_ok = &{1'b0, jdo[1:0], r_overrun, TIMEOUT_CYC[0]};

   assign avm_address    = r_addr;
   assign avm_writedata  = r_wdata;
   assign avm_byteenable = r_be;
   assign MonDReg        = r_mon;
   assign monitor_ready  = r_ready;
   assign monitor_error  = r_error;

endmodule

// File: tb/tb_dbg_mon_mem_engine.sv
// Directed bench for dbg_mon_mem_engine: a vector table of single ops plus hand-written corner sequences.
module tb_dbg_mon_mem_engine;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [37:0] jdo = '0;
   logic        take_action_ocimem_a = 1'b0;
   logic        take_action_ocimem_b = 1'b0;
   logic        take_no_action_ocimem_a = 1'b0;
   logic [7:0]  avm_address;
   logic        avm_read, avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest = 1'b0;
   logic [31:0] avm_readdata = '0;
   logic        avm_readdatavalid = 1'b0;
   logic [31:0] mon_dreg;
   logic        monitor_ready, monitor_error;

   int n_checks = 0;
   int n_err    = 0;

   localparam logic [2:0] S_B = 3'b100, S_A = 3'b010, S_N = 3'b001;
   localparam logic [1:0] OP_NONE = 2'b00, OP_RD = 2'b01, OP_WR = 2'b10;

   dbg_mon_mem_engine #(.ADDR_W(8), .TIMEOUT_CYC(255)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .avm_address             (avm_address),
      .avm_read                (avm_read),
      .avm_write               (avm_write),
      .avm_writedata           (avm_writedata),
      .avm_byteenable          (avm_byteenable),
      .avm_waitrequest         (avm_waitrequest),
      .avm_readdata            (avm_readdata),
      .avm_readdatavalid       (avm_readdatavalid),
      .MonDReg                 (mon_dreg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  stb;       // {ocimem_b, ocimem_a, no_action_a}
      logic [37:0] jdo;
      int          wait_cyc;  // cycles the slave holds waitrequest
      int          rdv_delay; // 0: readdatavalid with the accept, n: n cycles later
      logic [31:0] rdata;
      logic [1:0]  exp_op;    // {write, read}
      logic [7:0]  exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_mon;
      int          exp_lat;   // clock edges from strobe sample to monitor_ready
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [37:0] jdo_load(input logic [7:0] addr, input logic rd, input logic clr);
      logic [37:0] j;
      j        = '0;
      j[24:17] = addr;
      j[35]    = rd;
      j[2]     = clr;
      return j;
   endfunction

   function automatic logic [37:0] jdo_write(input logic [1:0] be, input logic [31:0] wdata);
      logic [37:0] j;
      j        = '0;
      j[37:36] = be;
      j[34:3]  = wdata;
      return j;
   endfunction

   function automatic vec_t mk(input string name, input logic [2:0] stb, input logic [37:0] j,
                               input int wt, input int rdv, input logic [31:0] rd,
                               input logic [1:0] op, input logic [7:0] ea, input logic [3:0] ebe,
                               input logic [31:0] emon, input int elat);
      vec_t v;
      v.name = name; v.stb = stb; v.jdo = j; v.wait_cyc = wt; v.rdv_delay = rdv; v.rdata = rd;
      v.exp_op = op; v.exp_addr = ea; v.exp_be = ebe; v.exp_mon = emon; v.exp_lat = elat;
      return v;
   endfunction

   // Called #1 after a rising edge; acts as a simple Avalon slave until monitor_ready returns.
   task automatic run_vec(input vec_t v);
      int          lat = 0, req_cyc = 0, after_acc = -1;
      logic        saw_rd = 1'b0, saw_wr = 1'b0, unstable = 1'b0;
      logic [7:0]  a0 = '0;
      logic [3:0]  be0 = '0;
      logic [31:0] wd0 = '0;
      jdo = v.jdo;
      {take_action_ocimem_b, take_action_ocimem_a, take_no_action_ocimem_a} = v.stb;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = v.rdata;
      @(posedge clk); #1;
      {take_action_ocimem_b, take_action_ocimem_a, take_no_action_ocimem_a} = 3'b000;
      lat = 1;
      while (!monitor_ready && lat < 300) begin
         avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
         if (avm_read || avm_write) begin
            if (req_cyc == 0) begin
               a0 = avm_address; be0 = avm_byteenable; wd0 = avm_writedata;
            end else if ({avm_address, avm_byteenable, avm_writedata} !== {a0, be0, wd0}) begin
               unstable = 1'b1;
            end
            saw_rd = saw_rd | avm_read;
            saw_wr = saw_wr | avm_write;
            avm_waitrequest = (req_cyc < v.wait_cyc);
            if (!avm_waitrequest) begin
               after_acc = 0;
               if (avm_read && v.rdv_delay == 0) avm_readdatavalid = 1'b1;
            end
            req_cyc++;
         end else if (after_acc >= 0) begin
            after_acc++;
            if (after_acc == v.rdv_delay) avm_readdatavalid = 1'b1;
         end
         @(posedge clk); #1;
         lat++;
      end
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
      check({v.name, " ready latency"}, lat, v.exp_lat);
      check({v.name, " op kind"}, {saw_wr, saw_rd}, v.exp_op);
      check({v.name, " request cycles"}, req_cyc, (v.exp_op != OP_NONE) ? v.wait_cyc + 1 : 0);
      check({v.name, " MonDReg"}, mon_dreg, v.exp_mon);
      check({v.name, " error"}, monitor_error, 1'b0);
      if (v.exp_op != OP_NONE) begin
         check({v.name, " address"}, a0, v.exp_addr);
         check({v.name, " stable request"}, unstable, 1'b0);
      end
      if (v.exp_op == OP_WR) begin
         check({v.name, " byteenable"}, be0, v.exp_be);
         check({v.name, " writedata"}, wd0, v.exp_mon);
      end
   endtask

   initial begin
      int cnt;
      vecs.push_back(mk("load 0x10",        S_A,       jdo_load(8'h10, 1'b0, 1'b0),   0, 0, 32'h0,         OP_NONE, 8'h00, 4'hF, 32'h0000_0000, 1));
      vecs.push_back(mk("read 0x10",        S_N,       38'h0,                         0, 0, 32'h1234_5678, OP_RD,   8'h10, 4'hF, 32'h1234_5678, 3));
      vecs.push_back(mk("write wait4",      S_B,       jdo_write(2'b00, 32'hCAFE_F00D), 4, 0, 32'h0,       OP_WR,   8'h11, 4'hF, 32'hCAFE_F00D, 6));
      vecs.push_back(mk("read late rdv",    S_N,       38'h0,                         0, 1, 32'hA5A5_0001, OP_RD,   8'h12, 4'hF, 32'hA5A5_0001, 3));
      vecs.push_back(mk("write be01",       S_B,       jdo_write(2'b01, 32'h0000_1234), 0, 0, 32'h0,       OP_WR,   8'h13, 4'h3, 32'h0000_1234, 2));
      vecs.push_back(mk("write be10",       S_B,       jdo_write(2'b10, 32'h8765_4321), 1, 0, 32'h0,       OP_WR,   8'h14, 4'h1, 32'h8765_4321, 3));
      vecs.push_back(mk("write be11",       S_B,       jdo_write(2'b11, 32'h0BAD_F00D), 0, 0, 32'h0,       OP_WR,   8'h15, 4'hF, 32'h0BAD_F00D, 2));
      vecs.push_back(mk("load+read 0xFF",   S_A,       jdo_load(8'hFF, 1'b1, 1'b0),   2, 2, 32'h5555_AAAA, OP_RD,   8'hFF, 4'hF, 32'h5555_AAAA, 6));
      vecs.push_back(mk("read wrap 0x00",   S_N,       38'h0,                         0, 0, 32'h0F0F_0F0F, OP_RD,   8'h00, 4'hF, 32'h0F0F_0F0F, 3));
      vecs.push_back(mk("b beats a",        S_B | S_A, jdo_write(2'b00, 32'h1111_2222), 0, 0, 32'h0,       OP_WR,   8'h01, 4'hF, 32'h1111_2222, 2));
      vecs.push_back(mk("a beats no_action", S_A | S_N, jdo_load(8'h40, 1'b0, 1'b0),  0, 0, 32'h0,         OP_NONE, 8'h00, 4'hF, 32'h1111_2222, 1));
      vecs.push_back(mk("read 0x40",        S_N,       38'h0,                         0, 0, 32'h0000_0001, OP_RD,   8'h40, 4'hF, 32'h0000_0001, 3));

      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      check("reset ready",     monitor_ready,  1'b1);
      check("reset error",     monitor_error,  1'b0);
      check("reset MonDReg",   mon_dreg,       32'h0);
      check("reset address",   avm_address,    8'h00);
      check("reset be",        avm_byteenable, 4'hF);
      check("reset writedata", avm_writedata,  32'h0);
      check("reset requests",  {avm_write, avm_read}, 2'b00);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Strobe while waiting in RD_DATA is dropped and flags an error.
      take_no_action_ocimem_a = 1'b1;
      @(posedge clk); #1;
      take_no_action_ocimem_a = 1'b0;
      check("busy read addr", avm_address, 8'h41);
      check("busy read req",  avm_read,    1'b1);
      @(posedge clk); #1;
      jdo = jdo_write(2'b00, 32'h7777_7777);
      take_action_ocimem_b = 1'b1;
      @(posedge clk); #1;
      take_action_ocimem_b = 1'b0;
      check("busy still waiting", monitor_ready, 1'b0);
      avm_readdata = 32'h9999_0000; avm_readdatavalid = 1'b1;
      @(posedge clk); #1;
      avm_readdatavalid = 1'b0;
      check("busy done ready",     monitor_ready, 1'b1);
      check("busy MonDReg",        mon_dreg,      32'h9999_0000);
      check("busy error set",      monitor_error, 1'b1);
      check("busy wdata kept",     avm_writedata, 32'h1111_2222);
      check("busy no write",       avm_write,     1'b0);
      check("busy addr advanced",  avm_address,   8'h42);

      jdo = jdo_load(8'h00, 1'b0, 1'b1);
      take_action_ocimem_a = 1'b1;
      @(posedge clk); #1;
      take_action_ocimem_a = 1'b0;
      check("clr_err error", monitor_error, 1'b0);
      check("clr_err addr",  avm_address,   8'h00);

      // readdatavalid with no read outstanding must not touch MonDReg.
      avm_readdata = 32'hDEAD_DEAD; avm_readdatavalid = 1'b1;
      @(posedge clk); #1;
      avm_readdatavalid = 1'b0;
      check("idle rdv MonDReg", mon_dreg,      32'h9999_0000);
      check("idle rdv ready",   monitor_ready, 1'b1);

`ifdef DBG_MEM_TIMEOUT_EN
      jdo = jdo_load(8'h20, 1'b0, 1'b0);
      take_action_ocimem_a = 1'b1;
      @(posedge clk); #1;
      take_action_ocimem_a = 1'b0;
      take_no_action_ocimem_a = 1'b1;
      avm_waitrequest = 1'b1;
      @(posedge clk); #1;
      take_no_action_ocimem_a = 1'b0;
      cnt = 0;
      while (avm_read && cnt < 400) begin
         cnt++;
         @(posedge clk); #1;
      end
      avm_waitrequest = 1'b0;
      check("timeout cycles",  cnt,           255);
      check("timeout MonDReg", mon_dreg,      32'hDEAD_BEEF);
      check("timeout error",   monitor_error, 1'b1);
      check("timeout addr",    avm_address,   8'h20);
      check("timeout ready",   monitor_ready, 1'b1);
`endif

      // Reset in the middle of a stalled read.
      take_no_action_ocimem_a = 1'b1;
      avm_waitrequest = 1'b1;
      @(posedge clk); #1;
      take_no_action_ocimem_a = 1'b0;
      check("pre-reset read", avm_read, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("async read drop",  avm_read,      1'b0);
      check("async ready",      monitor_ready, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      avm_waitrequest = 1'b0;
      @(posedge clk); #1;
      check("post-reset MonDReg", mon_dreg,      32'h0);
      check("post-reset address", avm_address,   8'h00);
      check("post-reset error",   monitor_error, 1'b0);
      cnt = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (avm_read || avm_write || !monitor_ready) cnt++;
      end
      check("no auto-retry", cnt, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
